// File: rtl/bcd_updown_counter.sv
// Multi-decade synchronous BCD up/down counter with parallel load, cascade
// carry in/out, optional saturation at terminal count and invalid-code recovery.
module bcd_updown_counter #(
  parameter int DIGITS   = 2,
  parameter bit SATURATE = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  dir,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   din,
  input  logic                  cin,
  output logic [4*DIGITS-1:0]   q,
  output logic                  tc,
  output logic                  cout,
  output logic                  wrap,
  output logic                  bcd_err
);

  localparam int W = 4 * DIGITS;

  logic          step;
  logic [W-1:0]  q_nxt;
  logic [DIGITS-1:0] term;

  // Invalid codes 10..15 are steered back into 0..9 within a few up-steps.
  function automatic logic [3:0] next_digit(input logic [3:0] d, input logic down);
    logic [3:0] r;
    if (down) begin
      r = (d == 4'd0) ? 4'd9 : d - 4'd1;
    end else begin
      case (d)
        4'd9:    r = 4'd0;
        4'd11:   r = 4'd6;
        4'd13:   r = 4'd4;
        4'd15:   r = 4'd2;
        default: r = d + 4'd1;
      endcase
    end
    return r;
  endfunction

  assign step = en & cin & ~load;

  always_comb begin
    logic carry;
    q_nxt   = q;
    term    = '0;
    bcd_err = 1'b0;
    carry   = step;
    for (int k = 0; k < DIGITS; k++) begin
      term[k] = dir ? (q[4*k +: 4] == 4'd0) : (q[4*k +: 4] == 4'd9);
      if (carry) q_nxt[4*k +: 4] = next_digit(q[4*k +: 4], dir);
      carry = carry & term[k];
      if (q[4*k +: 4] > 4'd9) bcd_err = 1'b1;
    end
  end

  assign tc   = &term;
  assign cout = tc & step;

  // Register stage: load beats count; terminal-state steps either wrap or hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q    <= '0;
      wrap <= 1'b0;
    end else if (load) begin
      q    <= din;
      wrap <= 1'b0;
    end else if (step) begin
      if (tc && SATURATE) begin
        wrap <= 1'b0;
      end else begin
        q    <= q_nxt;
        wrap <= tc;
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Randomised and directed bench for bcd_updown_counter (DIGITS=2), comparing a
// wrapping and a saturating instance against a decimal-value reference model.
module tb_bcd_updown_counter;

  logic       clk, rst, en, dir, load, cin;
  logic [7:0] din;
  logic [7:0] q_w, q_s;
  logic       tc_w, tc_s, cout_w, cout_s, wrap_w, wrap_s, err_w, err_s;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mq_w, mq_s;
  logic       mw_w, mw_s;

  bcd_updown_counter #(.DIGITS(2), .SATURATE(1'b0)) dut_w (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .din(din), .cin(cin),
    .q(q_w), .tc(tc_w), .cout(cout_w), .wrap(wrap_w), .bcd_err(err_w));

  bcd_updown_counter #(.DIGITS(2), .SATURATE(1'b1)) dut_s (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .din(din), .cin(cin),
    .q(q_s), .tc(tc_s), .cout(cout_s), .wrap(wrap_s), .bcd_err(err_s));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour: plain decimal arithmetic while both digits are valid,
  // digit-wise rules from the code table once an invalid code is present.
  function automatic logic m_term(input logic [7:0] v, input logic d);
    return d ? (v == 8'h00) : (v == 8'h99);
  endfunction

  function automatic int up_code(input int d);
    int tab [16] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 11, 6, 13, 4, 15, 2};
    return tab[d];
  endfunction

  function automatic logic [7:0] m_adv(input logic [7:0] v, input logic d);
    int lo, hi, n;
    lo = int'(v[3:0]);
    hi = int'(v[7:4]);
    if (lo <= 9 && hi <= 9) begin
      n = hi * 10 + lo;
      n = d ? (n + 99) % 100 : (n + 1) % 100;
      return 8'((n / 10) * 16 + (n % 10));
    end
    begin
      int nlo, nhi;
      nlo = d ? ((lo == 0) ? 9 : lo - 1) : up_code(lo);
      nhi = hi;
      if ((d && lo == 0) || (!d && lo == 9))
        nhi = d ? ((hi == 0) ? 9 : hi - 1) : up_code(hi);
      return 8'(nhi * 16 + nlo);
    end
  endfunction

  function automatic logic m_err(input logic [7:0] v);
    return (v[3:0] > 4'd9) || (v[7:4] > 4'd9);
  endfunction

  task automatic model_edge();
    logic stp;
    stp = en & cin & ~load;
    if (load) begin
      mq_w = din; mq_s = din; mw_w = 0; mw_s = 0;
    end else if (stp) begin
      if (m_term(mq_w, dir)) begin
        mq_w = dir ? 8'h99 : 8'h00; mw_w = 1;
      end else begin
        mq_w = m_adv(mq_w, dir); mw_w = 0;
      end
      if (!m_term(mq_s, dir)) mq_s = m_adv(mq_s, dir);
      mw_s = 0;
    end else begin
      mw_w = 0; mw_s = 0;
    end
  endtask

  task automatic check_comb();
    logic stp;
    stp = en & cin & ~load;
    chk("tc_w",   tc_w,   m_term(mq_w, dir));
    chk("tc_s",   tc_s,   m_term(mq_s, dir));
    chk("cout_w", cout_w, m_term(mq_w, dir) & stp);
    chk("cout_s", cout_s, m_term(mq_s, dir) & stp);
    chk("err_w",  err_w,  m_err(mq_w));
    chk("err_s",  err_s,  m_err(mq_s));
  endtask

  // Called at a falling edge with inputs already applied.
  task automatic tick(input bit do_rst = 0);
    #1 check_comb();
    if (do_rst) begin
      #1 rst = 1'b1;
      #1;
      chk("arst_q_w", q_w, 8'h00);
      chk("arst_q_s", q_s, 8'h00);
      chk("arst_wrap", wrap_w, 1'b0);
      chk("arst_tc", tc_w, dir);
      chk("arst_err", err_w, 1'b0);
      mq_w = 0; mq_s = 0; mw_w = 0; mw_s = 0;
      #1 rst = 1'b0;
    end
    @(posedge clk);
    model_edge();
    #1;
    chk("q_w",    q_w,    mq_w);
    chk("q_s",    q_s,    mq_s);
    chk("wrap_w", wrap_w, mw_w);
    chk("wrap_s", wrap_s, mw_s);
    @(negedge clk);
  endtask

  task automatic do_load(input logic [7:0] v);
    load = 1'b1; din = v;
    tick();
    load = 1'b0;
  endtask

  initial begin
    int wraps;
    rst = 1'b1; en = 0; dir = 0; load = 0; din = 0; cin = 0;
    mq_w = 0; mq_s = 0; mw_w = 0; mw_s = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_q", q_w, 8'h00);
    chk("rst_wrap", wrap_w, 1'b0);
    chk("rst_tc", tc_w, 1'b0);
    chk("rst_err", err_w, 1'b0);
    rst = 1'b0;

    // Full up-count 00..99..00; exactly one wrap pulse.
    en = 1; cin = 1; dir = 0;
    wraps = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (wrap_w) wraps++;
    end
    chk("upcount_end", q_w, 8'h00);
    chk("wrap_count", wraps, 1);

    // Down-count from 10 to 00, then flip direction at 00.
    en = 0; do_load(8'h10);
    en = 1; dir = 1;
    for (int i = 0; i < 10; i++) tick();
    chk("down_at_00", q_w, 8'h00);
    dir = 0; en = 0;
    #1 chk("dir_flip_tc", tc_w, 1'b0);
    en = 1;
    tick();
    chk("after_flip", q_w, 8'h01);

    // Invalid-digit recovery from FF.
    do_load(8'hFF);
    for (int i = 0; i < 12; i++) tick();

    // Load beats counting at the terminal state.
    do_load(8'h99);
    load = 1; din = 8'h42; en = 1;
    #1 chk("load_cout", cout_w, 1'b0);
    tick();
    load = 0;
    chk("load_prio", q_w, 8'h42);

    // Saturation vs. wrap at both terminal states.
    do_load(8'h99);
    for (int i = 0; i < 5; i++) tick();
    chk("sat_hold_up", q_s, 8'h99);
    dir = 1; do_load(8'h00);
    for (int i = 0; i < 3; i++) tick();
    chk("sat_hold_dn", q_s, 8'h00);

    // Asynchronous reset between edges at q=57.
    dir = 0; do_load(8'h57);
    en = 0;
    tick(1);
    en = 1;
    tick();
    chk("resume", q_w, 8'h01);

    // Random traffic, all din codes, cin held low occasionally.
    for (int i = 0; i < 400; i++) begin
      en   = ($urandom_range(0, 7) != 0);
      cin  = ($urandom_range(0, 5) != 0);
      dir  = ($urandom_range(0, 15) == 0) ? ~dir : dir;
      load = ($urandom_range(0, 15) == 0);
      din  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9) * 16 + $urandom_range(0, 9));
      tick($urandom_range(0, 99) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
